// File: rtl/sdio_cmd_sequencer.sv
// SDIO command-layer sequencer: decodes PHY commands, tracks RCA/selection,
// builds R4/R5/R6/R1 responses, runs CMD52 register accesses and arms the data PHY for CMD53.
module sdio_cmd_sequencer #(
  parameter logic [2:0]  NUM_FUNCS   = 3'd1,
  parameter logic [23:0] OCR         = 24'hFF8000,
  parameter logic [7:0]  REG_TIMEOUT = 8'd32
) (
  input  logic        i_sdio_clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic        i_cmd_crc_good_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_rsps_idle,
  output logic        o_rsps_stb,
  output logic [39:0] o_rsps,
  output logic [7:0]  o_rsps_len,
  output logic        o_rsps_fail,
  output logic        o_reg_stb,
  output logic        o_reg_wr,
  output logic [2:0]  o_reg_func,
  output logic [16:0] o_reg_addr,
  output logic [7:0]  o_reg_wdata,
  input  logic        i_reg_ack,
  input  logic [7:0]  i_reg_rdata,
  output logic        o_data_activate,
  output logic        o_write_flag,
  output logic [9:0]  o_data_count,
  input  logic        i_data_done,
  output logic [15:0] o_rca,
  output logic        o_selected
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_REG_WAIT, ST_RESPOND, ST_WAIT_RSPS, ST_DATA_BUSY
  } state_t;

  typedef enum logic [1:0] {CARD_INIT, CARD_STBY, CARD_CMD} card_t;

  state_t      state_q;
  card_t       cardState_q;
  logic [15:0] rca_q;
  logic [5:0]  cmdIdx_q;
  logic [31:0] arg_q;
  logic        crcOk_q;
  logic [7:0]  timer_q;
  logic        armed_q;
  logic        abort_q;
  logic        idlePrev_q;
  logic [39:0] rsps_q;
  logic        rspsStb_q;
  logic        rspsFail_q;
  logic        regStb_q;
  logic        regWr_q;
  logic [2:0]  regFunc_q;
  logic [16:0] regAddr_q;
  logic [7:0]  regWdata_q;
  logic        act_q;
  logic        writeFlag_q;
  logic [9:0]  dataCount_q;

  logic        argWr, argRaw, argBlock, funcBad, selected, idleRise, unusedArgBit;
  logic [2:0]  argFunc;
  logic [16:0] argAddr;
  logic [8:0]  argCount;
  logic [15:0] rcaNext_d;
  logic [1:0]  r5State_d;
  state_t      backState_d;

  assign argWr        = arg_q[31];
  assign argFunc      = arg_q[30:28];
  assign argRaw       = arg_q[27];
  assign argBlock     = arg_q[27];
  assign argAddr      = arg_q[25:9];
  assign argCount     = arg_q[8:0];
  assign unusedArgBit = arg_q[26];
  assign funcBad      = argFunc > NUM_FUNCS;
  assign selected     = cardState_q == CARD_CMD;
  assign idleRise     = i_rsps_idle && !idlePrev_q;
  assign rcaNext_d    = (rca_q == 16'hFFFF) ? 16'd1 : rca_q + 16'd1;
  // An abort ends the transfer, so its own R5 already reports CMD state.
  assign r5State_d    = (act_q && !abort_q) ? 2'b10 : 2'b01;
  assign backState_d  = act_q ? ST_DATA_BUSY : ST_IDLE;

  function automatic logic [39:0] mkRsp(input logic [5:0] idx, input logic [31:0] content);
    return {1'b0, idx, content, 1'b0};
  endfunction

  function automatic logic [39:0] mkR5(input logic [5:0] idx, input logic [1:0] st,
                                       input logic err, input logic fnErr, input logic [7:0] data);
    return mkRsp(idx, {16'h0000, 2'b00, st, err, 1'b0, fnErr, 1'b0, data});
  endfunction

  always_ff @(posedge i_sdio_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cardState_q <= CARD_INIT;
      rca_q       <= '0;
      cmdIdx_q    <= '0;
      arg_q       <= '0;
      crcOk_q     <= 1'b0;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      abort_q     <= 1'b0;
      idlePrev_q  <= 1'b0;
      rsps_q      <= '0;
      rspsStb_q   <= 1'b0;
      rspsFail_q  <= 1'b0;
      regStb_q    <= 1'b0;
      regWr_q     <= 1'b0;
      regFunc_q   <= '0;
      regAddr_q   <= '0;
      regWdata_q  <= '0;
      act_q       <= 1'b0;
      writeFlag_q <= 1'b0;
      dataCount_q <= '0;
    end else begin
      rspsStb_q  <= 1'b0;
      rspsFail_q <= 1'b0;
      regStb_q   <= 1'b0;
      idlePrev_q <= i_rsps_idle;
      case (state_q)
        ST_IDLE, ST_DATA_BUSY: begin
          if (state_q == ST_DATA_BUSY && i_data_done) begin
            act_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
          if (i_cmd_stb) begin
            cmdIdx_q <= i_cmd;
            arg_q    <= i_cmd_arg;
            crcOk_q  <= i_cmd_crc_good_stb;
            state_q  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q <= ST_RESPOND;
          if (!crcOk_q) begin
            rspsFail_q <= 1'b1;
            state_q    <= backState_d;
          end else begin
            case (cmdIdx_q)
              6'd5: begin
                rsps_q    <= mkRsp(6'h3F, {1'b1, NUM_FUNCS, 1'b0, 3'b000, OCR});
                rspsStb_q <= 1'b1;
              end
              6'd3: begin
                rca_q     <= rcaNext_d;
                if (cardState_q == CARD_INIT) cardState_q <= CARD_STBY;
                rsps_q    <= mkRsp(6'd3, {rcaNext_d, 16'h0000});
                rspsStb_q <= 1'b1;
              end
              6'd7: begin
                if (arg_q[31:16] == rca_q && rca_q != 16'd0) begin
                  cardState_q <= CARD_CMD;
                  rsps_q      <= mkRsp(6'd7, 32'h0000_0000);
                  rspsStb_q   <= 1'b1;
                end else begin
                  if (cardState_q == CARD_CMD) cardState_q <= CARD_STBY;
                  rspsFail_q <= 1'b1;
                  state_q    <= backState_d;
                end
              end
              6'd52: begin
                if (!selected) begin
                  rspsFail_q <= 1'b1;
                  state_q    <= backState_d;
                end else if (funcBad) begin
                  rsps_q    <= mkR5(6'd52, r5State_d, 1'b0, 1'b1, 8'h00);
                  rspsStb_q <= 1'b1;
                end else begin
                  regStb_q   <= 1'b1;
                  regWr_q    <= argWr;
                  regFunc_q  <= argFunc;
                  regAddr_q  <= argAddr;
                  regWdata_q <= arg_q[7:0];
                  timer_q    <= '0;
                  abort_q    <= act_q && argWr && argFunc == 3'd0 && argAddr == 17'h00006;
                  state_q    <= ST_REG_WAIT;
                end
              end
              6'd53: begin
                if (!selected || act_q) begin
                  rspsFail_q <= 1'b1;
                  state_q    <= backState_d;
                end else if (argBlock || funcBad) begin
                  rsps_q    <= mkR5(6'd53, 2'b01, argBlock, funcBad, 8'h00);
                  rspsStb_q <= 1'b1;
                end else begin
                  armed_q     <= 1'b1;
                  writeFlag_q <= argWr;
                  dataCount_q <= (argCount == 9'd0) ? 10'd512 : {1'b0, argCount};
                  rsps_q      <= mkR5(6'd53, 2'b10, 1'b0, 1'b0, 8'h00);
                  rspsStb_q   <= 1'b1;
                end
              end
              default: begin
                rspsFail_q <= 1'b1;
                state_q    <= backState_d;
              end
            endcase
          end
        end
        ST_REG_WAIT: begin
          // A plain write reports 0; reads and read-after-write return the register value.
          if (i_reg_ack || timer_q == REG_TIMEOUT - 8'd1) begin
            rsps_q    <= mkR5(6'd52, r5State_d, !i_reg_ack, 1'b0,
                              (i_reg_ack && (!regWr_q || argRaw)) ? i_reg_rdata : 8'h00);
            rspsStb_q <= 1'b1;
            if (abort_q) act_q <= 1'b0;
            abort_q   <= 1'b0;
            state_q   <= ST_RESPOND;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ST_RESPOND: state_q <= ST_WAIT_RSPS;
        ST_WAIT_RSPS: begin
          if (idleRise) begin
            if (armed_q) begin
              act_q   <= 1'b1;
              armed_q <= 1'b0;
              state_q <= ST_DATA_BUSY;
            end else begin
              state_q <= backState_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rsps_stb      = rspsStb_q;
  assign o_rsps          = rsps_q;
  assign o_rsps_len      = 8'd39;
  assign o_rsps_fail     = rspsFail_q;
  assign o_reg_stb       = regStb_q;
  assign o_reg_wr        = regWr_q;
  assign o_reg_func      = regFunc_q;
  assign o_reg_addr      = regAddr_q;
  assign o_reg_wdata     = regWdata_q;
  assign o_data_activate = act_q;
  assign o_write_flag    = writeFlag_q;
  assign o_data_count    = dataCount_q;
  assign o_rca           = rca_q;
  assign o_selected      = selected;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// Scoreboard bench for sdio_cmd_sequencer: directed commands push expected
// responses/register strobes into a queue that a separate monitor pops and compares.
module tb_sdio_cmd_sequencer;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_stb = 1'b0;
  logic        i_cmd_crc_good_stb = 1'b0;
  logic [5:0]  i_cmd = '0;
  logic [31:0] i_cmd_arg = '0;
  logic        i_rsps_idle = 1'b1;
  logic        o_rsps_stb;
  logic [39:0] o_rsps;
  logic [7:0]  o_rsps_len;
  logic        o_rsps_fail;
  logic        o_reg_stb;
  logic        o_reg_wr;
  logic [2:0]  o_reg_func;
  logic [16:0] o_reg_addr;
  logic [7:0]  o_reg_wdata;
  logic        i_reg_ack = 1'b0;
  logic [7:0]  i_reg_rdata = '0;
  logic        o_data_activate;
  logic        o_write_flag;
  logic [9:0]  o_data_count;
  logic        i_data_done = 1'b0;
  logic [15:0] o_rca;
  logic        o_selected;

  sdio_cmd_sequencer dut (
    .i_sdio_clk(clock), .rst(rst),
    .i_cmd_stb(i_cmd_stb), .i_cmd_crc_good_stb(i_cmd_crc_good_stb),
    .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_rsps_idle(i_rsps_idle),
    .o_rsps_stb(o_rsps_stb), .o_rsps(o_rsps), .o_rsps_len(o_rsps_len), .o_rsps_fail(o_rsps_fail),
    .o_reg_stb(o_reg_stb), .o_reg_wr(o_reg_wr), .o_reg_func(o_reg_func), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .i_reg_ack(i_reg_ack), .i_reg_rdata(i_reg_rdata),
    .o_data_activate(o_data_activate), .o_write_flag(o_write_flag), .o_data_count(o_data_count),
    .i_data_done(i_data_done), .o_rca(o_rca), .o_selected(o_selected)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;
    logic [39:0] val;
    int          lat;
    int          act;
    string       name;
  } exp_t;

  localparam int K_RSP  = 0;
  localparam int K_FAIL = 1;
  localparam int K_REG  = 2;

  exp_t expQ[$];
  int   errCount = 0;
  int   checkCount = 0;
  int   cycleCnt = 0;
  int   issueCycle = 0;
  logic noAck = 1'b0;
  logic [7:0] regRdata = 8'h00;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  function automatic logic [39:0] rsp(input logic [5:0] idx, input logic [31:0] content);
    return {1'b0, idx, content, 1'b0};
  endfunction

  task automatic pushRsp(input string name, input logic [5:0] idx, input logic [31:0] content,
                         input int lat, input int act);
    exp_t e;
    e.kind = K_RSP; e.val = rsp(idx, content); e.lat = lat; e.act = act; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic pushFail(input string name);
    exp_t e;
    e.kind = K_FAIL; e.val = '0; e.lat = 0; e.act = -1; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic pushReg(input string name, input logic wr, input logic [2:0] func,
                         input logic [16:0] addr, input logic [7:0] wdata);
    exp_t e;
    e.kind = K_REG; e.val = {11'b0, wr, func, addr, wdata}; e.lat = 0; e.act = -1; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic popCheck(input int kind, input logic [39:0] val);
    exp_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL unexpected_output: kind %0d value %h, expected nothing", kind, val);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.name, "_kind"}, 40'(kind), 40'(e.kind));
      checkOutput(e.name, val, e.val);
      if (kind == K_RSP && e.lat > 0)
        checkOutput({e.name, "_latency"}, 40'(cycleCnt - issueCycle), 40'(e.lat));
      if (kind == K_RSP && e.act >= 0)
        checkOutput({e.name, "_activate"}, {39'b0, o_data_activate}, 40'(e.act));
    end
  endtask

  // Monitor: compares every strobe the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (o_rsps_stb)  popCheck(K_RSP, o_rsps);
        if (o_rsps_fail) popCheck(K_FAIL, 40'b0);
        if (o_reg_stb)   popCheck(K_REG, {11'b0, o_reg_wr, o_reg_func, o_reg_addr, o_reg_wdata});
      end
    end
  end

  // PHY response path: goes busy after each response, idle again 5 cycles later.
  initial begin
    forever begin
      @(negedge clock);
      if (o_rsps_stb) begin
        i_rsps_idle = 1'b0;
        repeat (5) @(negedge clock);
        i_rsps_idle = 1'b1;
      end
    end
  end

  // Register space: acknowledges two cycles after each strobe unless disabled.
  initial begin
    forever begin
      @(negedge clock);
      if (o_reg_stb && !noAck) begin
        repeat (2) @(negedge clock);
        i_reg_rdata = regRdata;
        i_reg_ack = 1'b1;
        @(negedge clock);
        i_reg_ack = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic crc);
    @(negedge clock);
    i_cmd = idx;
    i_cmd_arg = arg;
    i_cmd_stb = 1'b1;
    i_cmd_crc_good_stb = crc;
    issueCycle = cycleCnt;
    @(negedge clock);
    i_cmd_stb = 1'b0;
    i_cmd_crc_good_stb = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkCount++;
    if (expQ.size() != 0) begin
      errCount++;
      $display("[TB] FAIL drain_timeout: %0d expected items outstanding, required 0", expQ.size());
      expQ.delete();
    end
    repeat (10) @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("reset_len", {32'b0, o_rsps_len}, 40'd39);
    checkOutput("reset_rca", {24'b0, o_rca}, 40'd0);
    checkOutput("reset_sel", {39'b0, o_selected}, 40'd0);
    checkOutput("reset_act", {39'b0, o_data_activate}, 40'd0);
    checkOutput("reset_rsps", o_rsps, 40'd0);

    pushFail("cmd52_unselected");
    applyStimulus(6'd52, 32'h1000_2000, 1'b1); waitDrain(20);

    pushRsp("cmd5_r4", 6'h3F, 32'h90FF_8000, 2, -1);
    applyStimulus(6'd5, 32'h0, 1'b1); waitDrain(20);

    pushFail("bad_crc");
    applyStimulus(6'd5, 32'h0, 1'b0); waitDrain(20);

    pushFail("unsupported_cmd0");
    applyStimulus(6'd0, 32'h0, 1'b1); waitDrain(20);

    pushRsp("cmd3_r6", 6'd3, 32'h0001_0000, 2, -1);
    applyStimulus(6'd3, 32'h0, 1'b1); waitDrain(20);
    checkOutput("rca_after_cmd3", {24'b0, o_rca}, 40'd1);

    pushFail("cmd7_wrong_rca");
    applyStimulus(6'd7, 32'h0002_0000, 1'b1); waitDrain(20);
    checkOutput("sel_after_bad_cmd7", {39'b0, o_selected}, 40'd0);

    pushRsp("cmd7_r1", 6'd7, 32'h0, 2, -1);
    applyStimulus(6'd7, 32'h0001_0000, 1'b1); waitDrain(20);
    checkOutput("sel_after_cmd7", {39'b0, o_selected}, 40'd1);

    regRdata = 8'hA5;
    pushReg("cmd52_rd_reg", 1'b0, 3'd1, 17'h10, 8'h00);
    pushRsp("cmd52_rd_r5", 6'd52, 32'h0000_10A5, 0, -1);
    applyStimulus(6'd52, 32'h1000_2000, 1'b1); waitDrain(30);

    regRdata = 8'h77;
    pushReg("cmd52_wr_reg", 1'b1, 3'd1, 17'h20, 8'h5A);
    pushRsp("cmd52_wr_r5", 6'd52, 32'h0000_1000, 0, -1);
    applyStimulus(6'd52, 32'h9000_405A, 1'b1); waitDrain(30);

    regRdata = 8'h3C;
    pushReg("cmd52_raw_reg", 1'b1, 3'd1, 17'h20, 8'h5A);
    pushRsp("cmd52_raw_r5", 6'd52, 32'h0000_103C, 0, -1);
    applyStimulus(6'd52, 32'h9800_405A, 1'b1); waitDrain(30);

    pushRsp("cmd52_badfunc_r5", 6'd52, 32'h0000_1200, 2, -1);
    applyStimulus(6'd52, 32'h2000_2000, 1'b1); waitDrain(20);

    noAck = 1'b1;
    pushReg("cmd52_to_reg", 1'b0, 3'd1, 17'h10, 8'h00);
    pushRsp("cmd52_timeout_r5", 6'd52, 32'h0000_1800, 0, -1);
    applyStimulus(6'd52, 32'h1000_2000, 1'b1); waitDrain(60);
    noAck = 1'b0;

    pushRsp("cmd53_block_r5", 6'd53, 32'h0000_1800, 2, 0);
    applyStimulus(6'd53, 32'h1800_0008, 1'b1); waitDrain(20);
    checkOutput("act_after_block", {39'b0, o_data_activate}, 40'd0);

    pushRsp("cmd53_wr_r5", 6'd53, 32'h0000_2000, 2, 0);
    applyStimulus(6'd53, 32'h9000_0000, 1'b1); waitDrain(20);
    checkOutput("act_after_cmd53", {39'b0, o_data_activate}, 40'd1);
    checkOutput("count_512", {30'b0, o_data_count}, 40'd512);
    checkOutput("write_flag", {39'b0, o_write_flag}, 40'd1);

    pushFail("cmd53_during_busy");
    applyStimulus(6'd53, 32'h1000_0004, 1'b1); waitDrain(20);

    regRdata = 8'hA5;
    pushReg("cmd52_busy_reg", 1'b0, 3'd1, 17'h10, 8'h00);
    pushRsp("cmd52_busy_r5", 6'd52, 32'h0000_20A5, 0, 1);
    applyStimulus(6'd52, 32'h1000_2000, 1'b1); waitDrain(30);
    checkOutput("act_after_busy52", {39'b0, o_data_activate}, 40'd1);

    pushReg("abort_reg", 1'b1, 3'd0, 17'h6, 8'h01);
    pushRsp("abort_r5", 6'd52, 32'h0000_1000, 0, 0);
    applyStimulus(6'd52, 32'h8000_0C01, 1'b1); waitDrain(30);
    checkOutput("act_after_abort", {39'b0, o_data_activate}, 40'd0);

    pushRsp("cmd53_rd_r5", 6'd53, 32'h0000_2000, 2, 0);
    applyStimulus(6'd53, 32'h1000_0005, 1'b1); waitDrain(20);
    checkOutput("act_rd", {39'b0, o_data_activate}, 40'd1);
    checkOutput("count_5", {30'b0, o_data_count}, 40'd5);
    checkOutput("read_flag", {39'b0, o_write_flag}, 40'd0);
    @(negedge clock); i_data_done = 1'b1;
    @(negedge clock); i_data_done = 1'b0;
    checkOutput("act_after_done", {39'b0, o_data_activate}, 40'd0);

    pushRsp("cmd53_pre_reset", 6'd53, 32'h0000_2000, 2, 0);
    applyStimulus(6'd53, 32'h9000_0010, 1'b1); waitDrain(20);
    checkOutput("act_pre_reset", {39'b0, o_data_activate}, 40'd1);
    @(negedge clock); rst = 1'b1;
    @(posedge clock); #1;
    checkOutput("act_reset", {39'b0, o_data_activate}, 40'd0);
    checkOutput("rca_reset", {24'b0, o_rca}, 40'd0);
    checkOutput("sel_reset", {39'b0, o_selected}, 40'd0);
    @(negedge clock); rst = 1'b0;
    repeat (5) @(negedge clock);

    waitDrain(5);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
